// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: access kinds, response status codes and index-width helper.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b00,
    RGGEN_WRITE        = 2'b01,
    RGGEN_READ         = 2'b10
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int rggen_index_width(int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// rggen register bus: request (valid/access/address/write_data/strobe) held until ready,
// response (ready/status/read_data) returned by the slave in the completing cycle.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  import rggen_rtl_pkg::*;

  logic                       valid;
  rggen_access                access;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     strobe;
  logic                       ready;
  rggen_status                status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick: first set request after last_index, wrapping, ending at last_index.
// Zero latency; no handshake of its own.
module rggen_round_robin_selector
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS = 2,
  parameter int IW    = rggen_index_width(HOSTS)
)(
  input  logic [HOSTS-1:0] request,
  input  logic [IW-1:0]    last_index,
  output logic             found,
  output logic [IW-1:0]    winner_index
);

  int            sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester after last_index wins.
  always_comb begin
    found        = 1'b0;
    winner_index = '0;
    sum          = 0;
    idx          = '0;
    for (int i = HOSTS; i >= 1; i--) begin
      sum = int'(last_index) + i;
      if (sum >= HOSTS) begin
        sum = sum - HOSTS;
      end
      idx = sum[IW-1:0];
      if (request[idx]) begin
        found        = 1'b1;
        winner_index = idx;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_mux_arbiter.sv
// Round-robin mux of HOSTS rggen buses onto one; grant registered in IDLE (1 cycle), held until ready.
// Responses pass through combinationally; non-granted hosts stall with ready=0.
module rggen_bus_mux_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  rggen_bus_if.slave  host_if[HOSTS],
  rggen_bus_if.master bus_if
);

  localparam int IW    = rggen_index_width(HOSTS);
  localparam int SLOTS = 1 << IW;
  localparam int SW    = BUS_WIDTH / 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                   state_q;
  state_e                   state_d;
  logic [IW-1:0]            grant_index;
  logic [IW-1:0]            last_index;
  logic                     busy;
  logic [HOSTS-1:0]         request;
  logic                     found;
  logic [IW-1:0]            winner_index;

  rggen_access              access_slot     [SLOTS];
  logic [ADDRESS_WIDTH-1:0] address_slot    [SLOTS];
  logic [BUS_WIDTH-1:0]     write_data_slot [SLOTS];
  logic [SW-1:0]            strobe_slot     [SLOTS];

  assign busy = (state_q == BUSY);

  // Slots beyond HOSTS are tied off so grant_index can index without a range check.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < HOSTS) begin : g_host
      logic selected;

      assign request[g]         = host_if[g].valid;
      assign access_slot[g]     = host_if[g].access;
      assign address_slot[g]    = host_if[g].address;
      assign write_data_slot[g] = host_if[g].write_data;
      assign strobe_slot[g]     = host_if[g].strobe;

      assign selected              = busy && (grant_index == IW'(g));
      assign host_if[g].ready      = selected && bus_if.ready;
      assign host_if[g].status     = selected ? bus_if.status : RGGEN_OKAY;
      assign host_if[g].read_data  = selected ? bus_if.read_data : '0;
    end else begin : g_pad
      assign access_slot[g]     = rggen_access'(2'b00);
      assign address_slot[g]    = '0;
      assign write_data_slot[g] = '0;
      assign strobe_slot[g]     = '0;
    end
  end

  rggen_round_robin_selector #(
    .HOSTS (HOSTS),
    .IW    (IW)
  ) u_selector (
    .request      (request),
    .last_index   (last_index),
    .found        (found),
    .winner_index (winner_index)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      grant_index <= '0;
      last_index  <= IW'(HOSTS - 1);
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && found) begin
        grant_index <= winner_index;
      end
      if ((state_q == BUSY) && bus_if.ready) begin
        last_index <= grant_index;
      end
    end
  end

  // Downstream valid depends only on registered state, never on a host's valid.
  always_comb begin
    state_d           = state_q;
    bus_if.valid      = 1'b0;
    bus_if.access     = rggen_access'(2'b00);
    bus_if.address    = '0;
    bus_if.write_data = '0;
    bus_if.strobe     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus_if.valid      = 1'b1;
        bus_if.access     = access_slot[grant_index];
        bus_if.address    = address_slot[grant_index];
        bus_if.write_data = write_data_slot[grant_index];
        bus_if.strobe     = strobe_slot[grant_index];
        if (bus_if.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rggen_bus_mux_arbiter.sv
// Directed bench for rggen_bus_mux_arbiter with three hosts: per-cycle vector table plus
// contention, reset-during-grant sequences.
module tb_rggen_bus_mux_arbiter;
  import rggen_rtl_pkg::*;

  localparam int N = 3;
  localparam rggen_access H_ACC  [N] = '{RGGEN_READ, RGGEN_WRITE, RGGEN_READ};
  localparam logic [15:0] H_ADDR [N] = '{16'h0010, 16'h0040, 16'h0080};
  localparam logic [31:0] H_WD   [N] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
  localparam logic [3:0]  H_STRB [N] = '{4'h0, 4'hC, 4'hF};

  typedef struct {
    logic [2:0]  hv;
    logic        rdy;
    rggen_status st;
    logic [31:0] rd;
    logic        e_bv;
    int          e_g;
    logic [2:0]  e_rdy;
    int          e_sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hv;
  logic        b_rdy;
  rggen_status b_st;
  logic [31:0] b_rd;
  logic [2:0]  h_ready;
  rggen_status h_status [N];
  logic [31:0] h_rdata  [N];
  int          total = 0;
  int          bad   = 0;
  vec_t        tbl[$];
  int          exp_order [6];

  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) host_if[N] ();
  rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus_if ();

  for (genvar i = 0; i < N; i++) begin : g_host
    assign host_if[i].valid      = hv[i];
    assign host_if[i].access     = H_ACC[i];
    assign host_if[i].address    = H_ADDR[i];
    assign host_if[i].write_data = H_WD[i];
    assign host_if[i].strobe     = H_STRB[i];
    assign h_ready[i]            = host_if[i].ready;
    assign h_status[i]           = host_if[i].status;
    assign h_rdata[i]            = host_if[i].read_data;
  end

  assign bus_if.ready     = b_rdy;
  assign bus_if.status    = b_st;
  assign bus_if.read_data = b_rd;

  rggen_bus_mux_arbiter #(
    .HOSTS         (N),
    .ADDRESS_WIDTH (16),
    .BUS_WIDTH     (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .host_if (host_if),
    .bus_if  (bus_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic e_bv, input int g);
    check({tag, " bus_valid"},  32'(bus_if.valid), 32'(e_bv));
    check({tag, " bus_access"}, 32'(bus_if.access), e_bv ? 32'(H_ACC[g[1:0]]) : 32'd0);
    check({tag, " bus_addr"},   32'(bus_if.address), e_bv ? 32'(H_ADDR[g[1:0]]) : 32'd0);
    check({tag, " bus_wdata"},  bus_if.write_data, e_bv ? H_WD[g[1:0]] : 32'd0);
    check({tag, " bus_strobe"}, 32'(bus_if.strobe), e_bv ? 32'(H_STRB[g[1:0]]) : 32'd0);
  endtask

  task automatic check_hosts(input string tag, input logic [2:0] e_rdy, input int e_sel,
                             input rggen_status st, input logic [31:0] rd);
    for (int h = 0; h < N; h++) begin
      check($sformatf("%s h%0d ready", tag, h), 32'(h_ready[h[1:0]]), 32'(e_rdy[h[1:0]]));
      check($sformatf("%s h%0d status", tag, h), 32'(h_status[h[1:0]]),
            (h == e_sel) ? 32'(st) : 32'(RGGEN_OKAY));
      check($sformatf("%s h%0d rdata", tag, h), h_rdata[h[1:0]], (h == e_sel) ? rd : 32'd0);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic r, input rggen_status s,
                              input logic [31:0] d, input logic ebv, input int eg,
                              input logic [2:0] erdy, input int esel);
    vec_t t;
    t.hv = v; t.rdy = r; t.st = s; t.rd = d;
    t.e_bv = ebv; t.e_g = eg; t.e_rdy = erdy; t.e_sel = esel;
    return t;
  endfunction

  initial begin
    int n;
    int gap;
    int cyc;
    int g;

    // Single-host read of 0x0010, completing two cycles after bus valid.
    tbl.push_back(mk(3'b000, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b001, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b001, 0, RGGEN_OKAY,   32'h0,         1, 0, 3'b000, 0));
    tbl.push_back(mk(3'b001, 0, RGGEN_OKAY,   32'h0,         1, 0, 3'b000, 0));
    tbl.push_back(mk(3'b001, 1, RGGEN_OKAY,   32'h1234_5678, 1, 0, 3'b001, 0));
    tbl.push_back(mk(3'b000, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    // Host 1 write forwarded; host 0 idle and unaffected.
    tbl.push_back(mk(3'b010, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b010, 0, RGGEN_OKAY,   32'hAAAA_5555, 1, 1, 3'b000, 1));
    tbl.push_back(mk(3'b010, 1, RGGEN_OKAY,   32'hAAAA_5555, 1, 1, 3'b010, 1));
    tbl.push_back(mk(3'b000, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    // Error response seen only by host 2.
    tbl.push_back(mk(3'b100, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b100, 1, RGGEN_SLVERR, 32'hCAFE_0000, 1, 2, 3'b100, 2));
    tbl.push_back(mk(3'b000, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    // Host 1 arrives in the completing cycle of host 0.
    tbl.push_back(mk(3'b001, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b011, 1, RGGEN_OKAY,   32'h1111_1111, 1, 0, 3'b001, 0));
    tbl.push_back(mk(3'b010, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b010, 0, RGGEN_OKAY,   32'h0,         1, 1, 3'b000, 1));
    tbl.push_back(mk(3'b010, 1, RGGEN_OKAY,   32'h2222_3333, 1, 1, 3'b010, 1));
    // Stray downstream ready while idle; then wrap-around fairness 2 before 0.
    tbl.push_back(mk(3'b000, 1, RGGEN_SLVERR, 32'h5A5A_5A5A, 0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b101, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b101, 1, RGGEN_DECERR, 32'h0BAD_0BAD, 1, 2, 3'b100, 2));
    tbl.push_back(mk(3'b101, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));
    tbl.push_back(mk(3'b101, 1, RGGEN_OKAY,   32'h4444_5555, 1, 0, 3'b001, 0));
    tbl.push_back(mk(3'b000, 0, RGGEN_OKAY,   32'h0,         0, 0, 3'b000, 3));

    exp_order = '{0, 1, 2, 0, 1, 2};

    // Reset state with every host requesting and a stray downstream response.
    rst_n = 1'b0;
    hv    = 3'b111;
    b_rdy = 1'b1;
    b_st  = RGGEN_SLVERR;
    b_rd  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    check_bus("reset", 1'b0, 0);
    check_hosts("reset", 3'b000, 3, RGGEN_OKAY, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    hv    = 3'b000;
    b_rdy = 1'b0;
    b_st  = RGGEN_OKAY;
    b_rd  = 32'h0;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      hv    = tbl[r].hv;
      b_rdy = tbl[r].rdy;
      b_st  = tbl[r].st;
      b_rd  = tbl[r].rd;
      #1;
      check_bus($sformatf("vec%0d", r), tbl[r].e_bv, tbl[r].e_g);
      check_hosts($sformatf("vec%0d", r), tbl[r].e_rdy, tbl[r].e_sel, tbl[r].st, tbl[r].rd);
    end

    // Three-way contention from reset, downstream answering in the first busy cycle.
    @(negedge clk);
    rst_n = 1'b0;
    hv    = 3'b000;
    b_rdy = 1'b0;
    b_st  = RGGEN_OKAY;
    b_rd  = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    hv    = 3'b111;
    n     = 0;
    gap   = 0;
    cyc   = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      b_rdy = bus_if.valid;
      #1;
      cyc++;
      if (bus_if.valid) begin
        g = 3;
        for (int h = 0; h < N; h++) begin
          if (bus_if.address == H_ADDR[h[1:0]]) g = h;
        end
        check($sformatf("contention grant%0d", n), 32'(g), 32'(exp_order[n]));
        check($sformatf("contention ready%0d", n), 32'(h_ready), 32'(1 << exp_order[n]));
        if (n > 0) check($sformatf("contention gap%0d", n), 32'(gap), 32'd1);
        n++;
        gap = 0;
      end else if (n > 0) begin
        gap++;
      end
    end
    if (n < 6) check("contention timeout", 32'(n), 32'd6);

    // Reset while host 1 holds the grant, then host 0 wins first after release.
    @(negedge clk);
    b_rdy = 1'b0;
    hv    = 3'b010;
    cyc   = 0;
    while (!bus_if.valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset granted addr", 32'(bus_if.address), 32'(H_ADDR[1]));
    #2;
    rst_n = 1'b0;
    b_rdy = 1'b1;
    #1;
    check_bus("midreset", 1'b0, 0);
    check_hosts("midreset", 3'b000, 3, RGGEN_OKAY, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    b_rdy = 1'b0;
    hv    = 3'b011;
    @(negedge clk);
    #1;
    check_bus("postreset", 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
